cbus_ram_responder: RTL and testbench

- Memory-side responder for the cache bus, i.e. the slave end of the cbus_req_t/cbus_resp_t interface that DCache drives through VCacheTop.
- Backs a word-addressed LUTRAM, serves single and burst reads/writes with programmable first-beat latency.
- Used as the memory model in cache unit benches and as on-chip scratch RAM behind the cache in simulation builds.

---
 rtl/cbus_ram_responder.sv | 153 +++++++++++++++
 tb/tb_cbus_ram_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_ram_responder.sv
// cbus_ram_responder: word-addressed LUTRAM slave for the cache bus, single and burst
// transfers with a fixed first-beat latency. Optional macro CBUS_RAM_RANDOM_STALL_EN adds LFSR ready stalls.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_ram_responder
  import cbus_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                 state_q, state_d;
  logic                   is_write_q, is_write_d;
  logic [ADDR_BITS-1:0]   base_q, base_d;
  logic [7:0]             len_q, len_d;
  logic [7:0]             beat_q, beat_d;
  logic [7:0]             lat_q, lat_d;

  logic [31:0]            mem [DEPTH];
  logic [ADDR_BITS-1:0]   beat_idx;
  logic                   ready;
  logic                   last;
  logic                   stall_ok;
  logic                   unused_req_bits;

  // size, sub-word offset and aliasing upper address bits carry no meaning here
  assign unused_req_bits = ^{creq.size, creq.addr[1:0], creq.addr[31:ADDR_BITS+2]};

  assign beat_idx = base_q + ADDR_BITS'(beat_q);

`ifdef CBUS_RAM_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end

  assign stall_ok = (lfsr_q[1:0] != 2'b00);
`else
  assign stall_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      base_q     <= base_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
    end
  end

  // Dropping valid anywhere after acceptance abandons the transaction
  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    base_d     = base_q;
    len_d      = len_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    case (state_q)
      IDLE: begin
        if (creq.valid) begin
          is_write_d = creq.is_write;
          base_d     = creq.addr[ADDR_BITS+1:2];
          len_d      = creq.len;
          beat_d     = '0;
          lat_d      = 8'(LATENCY);
          state_d    = (LATENCY == 0) ? BURST : WAIT;
        end
      end
      WAIT: begin
        if (!creq.valid) begin
          lat_d   = '0;
          state_d = IDLE;
        end else begin
          lat_d = lat_q - 8'd1;
          if (lat_q == 8'd1) state_d = BURST;
        end
      end
      BURST: begin
        if (!creq.valid) begin
          beat_d  = '0;
          state_d = IDLE;
        end else if (ready) begin
          if (last) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready       = (state_q == BURST) && creq.valid && stall_ok;
    last        = ready && (beat_q == len_q);
    cresp.ready = ready;
    cresp.last  = last;
    cresp.data  = ready ? mem[beat_idx] : 32'd0;
  end

  // Memory is deliberately unreset so contents survive a reset
  always_ff @(posedge clk) begin
    if (ready && is_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (creq.strobe[i]) mem[beat_idx][8*i +: 8] <= creq.data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Bench for cbus_ram_responder: per-transaction expectations from a word-array model,
// checked every cycle, plus literal readback checks for the directed scenarios.
module tb_cbus_ram_responder;
  import cbus_pkg::*;

  localparam int AB    = 12;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AB;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  always #5 clk = ~clk;

  cbus_ram_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .creq   (creq),
    .cresp  (cresp)
  );

  logic [31:0] model_mem [DEPTH];
  logic        exp_ready, exp_last, chk_data;
  logic [31:0] exp_data;
  bit          cmp_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_q [$];
  logic [31:0] saved [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_exp(input logic r, input logic l, input logic c, input logic [31:0] d);
    exp_ready = r;
    exp_last  = l;
    chk_data  = c;
    exp_data  = d;
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] rd_at(input int k);
    if (k < rd_q.size()) return rd_q[k];
    return 32'hxxxxxxxx;
  endfunction

  // Per-cycle compare; read beats seen by the DUT are also collected for literal checks
  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready", 32'(cresp.ready), 32'(exp_ready));
      check("last", 32'(cresp.last), 32'(exp_last));
      if (chk_data) check("data", cresp.data, exp_data);
      if (exp_ready && chk_data) rd_q.push_back(cresp.data);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      creq.valid = 1'b0;
      creq.addr  = $urandom;
      set_exp(1'b0, 1'b0, 1'b1, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // dmode: 0 random data/strobe, 1 data=dval+beat with strb, 2 random data with strb
  // stop_cyc counts cycles after acceptance; -1 runs to completion
  task automatic run_txn(input bit wr, input logic [31:0] addr, input int len,
                         input int dmode, input logic [31:0] dval, input logic [3:0] strb,
                         input int stop_cyc, input bit stop_rst);
    int base, idx, k, total;
    base  = int'(addr[AB+1:2]);
    total = LAT + len + 1;
    idx   = 0;
    rd_q.delete();
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = 3'($urandom);
    creq.addr     = addr;
    creq.len      = 8'(len);
    creq.strobe   = 4'($urandom);
    creq.data     = $urandom;
    set_exp(1'b0, 1'b0, 1'b1, 32'd0);
    @(posedge clk); #1;
    for (int c = 1; c <= total; c++) begin
      if (c == stop_cyc) begin
        if (stop_rst) begin
          #2;
          set_exp(1'b0, 1'b0, 1'b1, 32'd0);
          resetn = 1'b0;
          #1;
          check("async_rst_ready", 32'(cresp.ready), 32'd0);
          check("async_rst_last", 32'(cresp.last), 32'd0);
          check("async_rst_data", cresp.data, 32'd0);
          creq.valid = 1'b0;
          @(posedge clk); #1;
          @(posedge clk); #1;
          resetn = 1'b1;
        end else begin
          creq.valid = 1'b0;
          set_exp(1'b0, 1'b0, 1'b1, 32'd0);
          @(posedge clk); #1;
        end
        return;
      end
      creq.is_write = 1'($urandom);
      creq.addr     = $urandom;
      creq.len      = 8'($urandom);
      creq.size     = 3'($urandom);
      if (c <= LAT) begin
        creq.data   = $urandom;
        creq.strobe = 4'($urandom);
        set_exp(1'b0, 1'b0, 1'b1, 32'd0);
      end else begin
        k   = c - LAT - 1;
        idx = (base + k) % DEPTH;
        if (wr) begin
          case (dmode)
            1:       begin creq.data = dval + 32'(k); creq.strobe = strb; end
            2:       begin creq.data = $urandom;      creq.strobe = strb; end
            default: begin creq.data = $urandom;      creq.strobe = 4'($urandom); end
          endcase
          set_exp(1'b1, k == len, 1'b0, 32'd0);
        end else begin
          creq.data   = $urandom;
          creq.strobe = 4'($urandom);
          set_exp(1'b1, k == len, 1'b1, model_mem[idx]);
        end
      end
      @(posedge clk);
      if (wr && c > LAT) model_write(idx, creq.data, creq.strobe);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] a;
    int          len, stop;
    creq   = '0;
    resetn = 1'b1;
    set_exp(1'b0, 1'b0, 1'b1, 32'd0);
    #1 resetn = 1'b0;
    #3;
    check("reset_ready", 32'(cresp.ready), 32'd0);
    check("reset_last", 32'(cresp.last), 32'd0);
    check("reset_data", cresp.data, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    cmp_en = 1'b1;
    idle(1);

    $display("[TB] prefill memory");
    for (int b = 0; b < 16; b++)
      run_txn(1'b1, 32'(b * 256 * 4), 255, 2, 32'd0, 4'hF, -1, 1'b0);

    $display("[TB] single word write/read");
    run_txn(1'b1, 32'h0000_0010, 0, 1, 32'hDEADBEEF, 4'hF, -1, 1'b0);
    check("model_pin_word", model_mem[4], 32'hDEADBEEF);
    run_txn(1'b0, 32'h0000_0010, 0, 0, 32'd0, 4'h0, -1, 1'b0);
    check("single_readback", rd_at(0), 32'hDEADBEEF);

    $display("[TB] byte strobe write");
    run_txn(1'b1, 32'h0000_0010, 0, 1, 32'h11223344, 4'b0101, -1, 1'b0);
    check("model_pin_strobe", model_mem[4], 32'hDE22BE44);
    run_txn(1'b0, 32'h0000_0010, 0, 0, 32'd0, 4'h0, -1, 1'b0);
    check("strobe_readback", rd_at(0), 32'hDE22BE44);

    $display("[TB] 16 beat burst");
    run_txn(1'b1, 32'h0000_0100, 15, 1, 32'd0, 4'hF, -1, 1'b0);
    run_txn(1'b0, 32'h0000_0100, 15, 0, 32'd0, 4'h0, -1, 1'b0);
    check("burst_beats", 32'(rd_q.size()), 32'd16);
    for (int k = 0; k < 16; k++) check("burst_data", rd_at(k), 32'(k));

    $display("[TB] wrapping burst");
    run_txn(1'b1, 32'h0000_3FFC, 3, 1, 32'h0000_00A0, 4'hF, -1, 1'b0);
    run_txn(1'b0, 32'h0000_3FFC, 3, 0, 32'd0, 4'h0, -1, 1'b0);
    for (int k = 0; k < 4; k++) check("wrap_data", rd_at(k), 32'h0000_00A0 + 32'(k));
    run_txn(1'b0, 32'h0000_0000, 0, 0, 32'd0, 4'h0, -1, 1'b0);
    check("wrap_idx0", rd_at(0), 32'h0000_00A1);

    $display("[TB] aborted write burst");
    for (int k = 0; k < 8; k++) saved[k] = model_mem[128 + k];
    run_txn(1'b1, 32'h0000_0200, 7, 1, 32'h5555_0000, 4'hF, LAT + 1 + 2, 1'b0);
    run_txn(1'b0, 32'h0000_0200, 7, 0, 32'd0, 4'h0, -1, 1'b0);
    check("abort_beats", 32'(rd_q.size()), 32'd8);
    check("abort_w0", rd_at(0), 32'h5555_0000);
    check("abort_w1", rd_at(1), 32'h5555_0001);
    for (int k = 2; k < 8; k++) check("abort_kept", rd_at(k), saved[k]);

    $display("[TB] reset during read burst");
    run_txn(1'b0, 32'h0000_0100, 15, 0, 32'd0, 4'h0, LAT + 1 + 5, 1'b1);
    run_txn(1'b0, 32'h0000_0100, 15, 0, 32'd0, 4'h0, -1, 1'b0);
    for (int k = 0; k < 16; k++) check("post_reset_data", rd_at(k), 32'(k));

    $display("[TB] random transactions");
    for (int t = 0; t < 80; t++) begin
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[AB+1:2] = AB'(DEPTH - 1 - int'($urandom_range(0, 3)));
      len  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 16));
      stop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, LAT + len + 1)) : -1;
      run_txn(1'($urandom), a, len, 0, 32'd0, 4'h0, stop, 1'b0);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(2);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
